// File: rtl/jk_pkg.sv
// rtl/jk_pkg.sv - shared encodings and excitation helper for the JK bank driver
// Contents:
//   OP_LOAD/OP_CLEAR/OP_INC/OP_XOR  command opcode encodings (2 bits)
//   state_t                         controller state enum (S_IDLE, S_DRIVE, S_CHECK)
//   jk_excite(q, tgt)               one-bit {j,k} excitation using set/reset/hold only
package jk_pkg;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_CLEAR = 2'b01;
    localparam logic [1:0] OP_INC   = 2'b10;
    localparam logic [1:0] OP_XOR   = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_CHECK = 2'd2
    } state_t;

    // Toggle (11) is never produced: a bit that already matches gets hold (00).
    function automatic logic [1:0] jk_excite(input logic q, input logic tgt);
        return {tgt & ~q, ~tgt & q};
    endfunction

endpackage

// File: rtl/jk_excite_bit.sv
// rtl/jk_excite_bit.sv - one-bit combinational JK excitation
// Ports:
//   q    in   present Q of one flip-flop
//   tgt  in   desired next Q
//   j    out  J excitation
//   k    out  K excitation
module jk_excite_bit
    import jk_pkg::*;
(
    input  logic q,
    input  logic tgt,
    output logic j,
    output logic k
);

    assign {j, k} = jk_excite(q, tgt);

endmodule

// File: rtl/jk_bank_driver.sv
// rtl/jk_bank_driver.sv - command-driven J/K driver with read-back verify and retry
// Ports:
//   clk        in   rising-edge clock shared with the JK bank
//   rst        in   synchronous active-high reset
//   cmd_valid  in   command present
//   cmd_ready  out  idle; command accepted when cmd_valid & cmd_ready
//   cmd_op     in   00 LOAD, 01 CLEAR, 10 INC, 11 XOR_MASK
//   cmd_data   in   LOAD value / XOR mask
//   q_in       in   present Q of the JK bank
//   j_out      out  registered J drive
//   k_out      out  registered K drive
//   done       out  one-cycle completion pulse (pass or fail)
//   error      out  sticky retry-exhaustion flag, cleared on next accept
//   busy       out  inverse of cmd_ready
module jk_bank_driver
    import jk_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MAX_RETRY = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [WIDTH-1:0] q_in,
    output logic [WIDTH-1:0] j_out,
    output logic [WIDTH-1:0] k_out,
    output logic             done,
    output logic             error,
    output logic             busy
);

    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] tgt;
    logic [WIDTH-1:0] tgt_next;
    logic [WIDTH-1:0] exc_tgt;
    logic [WIDTH-1:0] j_exc;
    logic [WIDTH-1:0] k_exc;
    logic [RW-1:0]    retry_cnt;
    logic             accept;
    logic             pass;
    logic             can_retry;

    // Target as seen on the accept cycle.
    always_comb begin
        tgt_next = '0;
        case (cmd_op)
            OP_LOAD:  tgt_next = cmd_data;
            OP_CLEAR: tgt_next = '0;
            OP_INC:   tgt_next = q_in + WIDTH'(1);
            OP_XOR:   tgt_next = q_in ^ cmd_data;
            default:  tgt_next = '0;
        endcase
    end

    // In IDLE the excitation feeds the first drive from the incoming command;
    // in CHECK it feeds a retry from the latched target.
    assign exc_tgt = (state == S_IDLE) ? tgt_next : tgt;

    for (genvar i = 0; i < WIDTH; i++) begin : g_exc
        jk_excite_bit u_exc (
            .q   (q_in[i]),
            .tgt (exc_tgt[i]),
            .j   (j_exc[i]),
            .k   (k_exc[i])
        );
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (cmd_valid) state_next = S_DRIVE;
            S_DRIVE: state_next = S_CHECK;
            S_CHECK: begin
                if (pass)           state_next = S_IDLE;
                else if (can_retry) state_next = S_DRIVE;
                else                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Combinational outputs and decision terms
    always_comb begin
        cmd_ready = (state == S_IDLE);
        busy      = (state != S_IDLE);
        accept    = cmd_valid && (state == S_IDLE);
        pass      = (q_in == tgt);
        can_retry = (retry_cnt < RW'(MAX_RETRY));
    end

    // Registered datapath; j/k default to hold so every non-drive cycle is 00.
    always_ff @(posedge clk) begin
        if (rst) begin
            j_out     <= '0;
            k_out     <= '0;
            done      <= 1'b0;
            error     <= 1'b0;
            tgt       <= '0;
            retry_cnt <= '0;
        end else begin
            j_out <= '0;
            k_out <= '0;
            done  <= 1'b0;
            if (accept) begin
                tgt       <= tgt_next;
                retry_cnt <= '0;
                error     <= 1'b0;
                j_out     <= j_exc;
                k_out     <= k_exc;
            end else if (state == S_CHECK) begin
                if (pass) begin
                    done  <= 1'b1;
                    error <= 1'b0;
                end else if (can_retry) begin
                    retry_cnt <= retry_cnt + RW'(1);
                    j_out     <= j_exc;
                    k_out     <= k_exc;
                end else begin
                    done  <= 1'b1;
                    error <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_jk_bank_driver.sv
// tb/tb_jk_bank_driver.sv - self-checking bench for jk_bank_driver with a JK bank model
module tb_jk_bank_driver;

    localparam int W  = 4;
    localparam int MR = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [W-1:0] cmd_data;
    logic [W-1:0] q_in;
    logic [W-1:0] j_out;
    logic [W-1:0] k_out;
    logic         done;
    logic         error;
    logic         busy;

    logic [W-1:0] bank_q;
    logic [W-1:0] stuck0;
    logic         preload_en;
    logic [W-1:0] preload_val;

    int total = 0;
    int bad   = 0;
    int overlap_cnt = 0;

    always #5 clk = ~clk;

    jk_bank_driver #(.WIDTH(W), .MAX_RETRY(MR)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .q_in      (q_in),
        .j_out     (j_out),
        .k_out     (k_out),
        .done      (done),
        .error     (error),
        .busy      (busy)
    );

    // Bank of JK flip-flops, with optional stuck-at-0 read-back bits.
    always @(posedge clk) begin
        if (preload_en) bank_q <= preload_val;
        else begin
            for (int i = 0; i < W; i++) begin
                case ({j_out[i], k_out[i]})
                    2'b10:   bank_q[i] <= 1'b1;
                    2'b01:   bank_q[i] <= 1'b0;
                    2'b11:   bank_q[i] <= ~bank_q[i];
                    default: bank_q[i] <= bank_q[i];
                endcase
            end
        end
    end
    assign q_in = bank_q & ~stuck0;

    always @(negedge clk) if ((j_out & k_out) != '0) overlap_cnt++;

    // Reference model: what the bank should end up holding.
    function automatic logic [W-1:0] model_tgt(input logic [1:0] op, input logic [W-1:0] d,
                                               input logic [W-1:0] q);
        int v;
        case (op)
            2'b00:   v = int'(d);
            2'b01:   v = 0;
            2'b10:   v = (int'(q) + 1) % (1 << W);
            default: v = int'(q ^ d);
        endcase
        return v[W-1:0];
    endfunction

    // Bits that must rise get J, bits that must fall get K, everything else holds.
    function automatic logic [W-1:0] model_set(input logic [W-1:0] q, input logic [W-1:0] t);
        logic [W-1:0] r = '0;
        for (int i = 0; i < W; i++) if (q[i] == 1'b0 && t[i] == 1'b1) r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [W-1:0] model_clr(input logic [W-1:0] q, input logic [W-1:0] t);
        logic [W-1:0] r = '0;
        for (int i = 0; i < W; i++) if (q[i] == 1'b1 && t[i] == 1'b0) r[i] = 1'b1;
        return r;
    endfunction

    task automatic preload(input logic [W-1:0] v);
        @(negedge clk);
        preload_en = 1'b1; preload_val = v;
        @(negedge clk);
        preload_en = 1'b0;
    endtask

    // Present one command from a negedge, return first-drive j/k, error on the
    // drive cycle and cycles from accept to done (capped at 30).
    task automatic issue(input logic [1:0] op, input logic [W-1:0] d, output int lat,
                         output logic [W-1:0] j1, output logic [W-1:0] k1,
                         output logic err1, output logic rdy0);
        rdy0 = cmd_ready;
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
        @(negedge clk);
        cmd_valid = 1'b0;
        j1 = j_out; k1 = k_out; err1 = error;
        lat = 1;
        while (!done && lat < 30) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (j_out !== '0)     begin bad++; $display("FAIL reset_j got=%h want=0", j_out); end
        total++; if (k_out !== '0)     begin bad++; $display("FAIL reset_k got=%h want=0", k_out); end
        total++; if (done !== 1'b0)    begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (error !== 1'b0)   begin bad++; $display("FAIL reset_error got=%b want=0", error); end
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", cmd_ready); end
        total++; if (busy !== 1'b0)    begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        rst = 1'b0;
    endtask

    task automatic test_single(input string name, input logic [W-1:0] q0, input logic [1:0] op,
                               input logic [W-1:0] d);
        int lat; logic [W-1:0] j1, k1, t; logic e1, r0;
        preload(q0);
        t = model_tgt(op, d, q0);
        issue(op, d, lat, j1, k1, e1, r0);
        total++; if (r0 !== 1'b1) begin bad++; $display("FAIL %s_ready got=%b want=1", name, r0); end
        total++; if (j1 !== model_set(q0, t)) begin bad++; $display("FAIL %s_j got=%b want=%b", name, j1, model_set(q0, t)); end
        total++; if (k1 !== model_clr(q0, t)) begin bad++; $display("FAIL %s_k got=%b want=%b", name, k1, model_clr(q0, t)); end
        total++; if (lat != 3) begin bad++; $display("FAIL %s_latency got=%0d want=3", name, lat); end
        total++; if (error !== 1'b0) begin bad++; $display("FAIL %s_error got=%b want=0", name, error); end
        total++; if (q_in !== t) begin bad++; $display("FAIL %s_q got=%h want=%h", name, q_in, t); end
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL %s_ready_on_done got=%b want=1", name, cmd_ready); end
    endtask

    task automatic test_stuck;
        int lat; logic [W-1:0] j1, k1; logic e1, r0;
        preload(4'h0);
        stuck0 = 4'b0001;
        issue(2'b00, 4'h1, lat, j1, k1, e1, r0);
        total++; if (lat != 3 + 2 * MR) begin bad++; $display("FAIL stuck_latency got=%0d want=%0d", lat, 3 + 2 * MR); end
        total++; if (error !== 1'b1) begin bad++; $display("FAIL stuck_error got=%b want=1", error); end
        @(negedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL stuck_done_pulse got=%b want=0", done); end
        total++; if (error !== 1'b1) begin bad++; $display("FAIL stuck_error_sticky got=%b want=1", error); end
        stuck0 = '0;
        issue(2'b00, 4'h2, lat, j1, k1, e1, r0);
        total++; if (e1 !== 1'b0) begin bad++; $display("FAIL stuck_error_clear got=%b want=0", e1); end
        total++; if (lat != 3) begin bad++; $display("FAIL stuck_recover_latency got=%0d want=3", lat); end
        total++; if (q_in !== 4'h2) begin bad++; $display("FAIL stuck_recover_q got=%h want=2", q_in); end
    endtask

    task automatic test_reset_mid;
        preload(4'h5);
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 4'hA;
        @(negedge clk);
        cmd_valid = 1'b0;
        total++; if (j_out !== 4'b1010) begin bad++; $display("FAIL midrst_drive_j got=%b want=1010", j_out); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if ((j_out | k_out) !== '0) begin bad++; $display("FAIL midrst_jk got=%b/%b want=0/0", j_out, k_out); end
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL midrst_ready got=%b want=1", cmd_ready); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL midrst_done got=%b want=0", done); end
        total++; if (q_in !== 4'hA) begin bad++; $display("FAIL midrst_q got=%h want=a", q_in); end
        repeat (3) @(negedge clk);
        total++; if (done !== 1'b0 || q_in !== 4'hA) begin bad++; $display("FAIL midrst_quiet got done=%b q=%h want done=0 q=a", done, q_in); end
    endtask

    task automatic test_back_to_back;
        int n;
        preload(4'h0);
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 4'h3;
        @(negedge clk);
        cmd_op = 2'b01; cmd_data = 4'($urandom_range(0, 15));
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy1 got=%b want=1", busy); end
        n = 1;
        while (!done && n < 20) begin @(negedge clk); n++; end
        total++; if (n != 3) begin bad++; $display("FAIL b2b_lat1 got=%0d want=3", n); end
        total++; if (q_in !== 4'h3) begin bad++; $display("FAIL b2b_q1 got=%h want=3", q_in); end
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b want=1", cmd_ready); end
        @(negedge clk);
        cmd_valid = 1'b0;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL b2b_busy2 got=%b want=1", busy); end
        n = 1;
        while (!done && n < 20) begin @(negedge clk); n++; end
        total++; if (n != 3) begin bad++; $display("FAIL b2b_lat2 got=%0d want=3", n); end
        total++; if (q_in !== 4'h0) begin bad++; $display("FAIL b2b_q2 got=%h want=0", q_in); end
    endtask

    task automatic test_random;
        int lat; logic [W-1:0] q0, d, t, j1, k1; logic [1:0] op; logic e1, r0;
        for (int it = 0; it < 24; it++) begin
            q0 = 4'($urandom_range(0, 15));
            d  = 4'($urandom_range(0, 15));
            op = 2'($urandom_range(0, 3));
            preload(q0);
            t = model_tgt(op, d, q0);
            issue(op, d, lat, j1, k1, e1, r0);
            total++;
            if (j1 !== model_set(q0, t) || k1 !== model_clr(q0, t) || lat != 3 ||
                error !== 1'b0 || q_in !== t) begin
                bad++;
                $display("FAIL rand%0d op=%0d q0=%h d=%h got j=%b k=%b lat=%0d err=%b q=%h want j=%b k=%b lat=3 err=0 q=%h",
                         it, op, q0, d, j1, k1, lat, error, q_in, model_set(q0, t), model_clr(q0, t), t);
            end
        end
    endtask

    task automatic test_no_overlap;
        total++; if (overlap_cnt != 0) begin bad++; $display("FAIL jk_overlap got=%0d want=0", overlap_cnt); end
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0;
        stuck0 = '0; preload_en = 1'b0; preload_val = '0;
        test_reset;
        test_single("load", 4'h5, 2'b00, 4'hA);
        test_single("inc_wrap", 4'hF, 2'b10, 4'h0);
        test_single("xor_zero", 4'h6, 2'b11, 4'h0);
        test_single("clear", 4'h9, 2'b01, 4'h7);
        test_stuck;
        test_reset_mid;
        test_back_to_back;
        test_random;
        test_no_overlap;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
